// File: rtl/pb_bus_master.sv
// rtl/pb_bus_master.sv - PicoBlaze-style port bus initiator with command FIFO and response channel
//
// Purpose:
//   Buffers read/write commands from a valid/ready source in a DEPTH-entry FIFO and issues
//   one registered single-cycle rd_o/wr_o strobe per command, strictly in order. Reads return
//   the combinational bus data through a valid/ready response channel. Strobes are always
//   separated by at least one idle cycle.
//
// Optional feature (macro PB_BUS_MASTER_WRACK_EN):
//   defined   - every write also produces a response (rsp_we_o = 1, written address/data)
//               and the next command waits for its handshake.
//   undefined - writes produce no response; rsp_we_o stays 0.
//
// Ports:
//   clk_i, rst_n_i                         clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o                command handshake
//   cmd_we_i, cmd_addr_i, cmd_data_i       command fields (data ignored for reads)
//   rsp_valid_o/rsp_ready_i                response handshake
//   rsp_we_o, rsp_addr_o, rsp_data_o       response fields
//   addr_o, data_o, rd_o, wr_o, data_i     port bus (data_i combinational while rd_o high)
//   fifo_count_o                           FIFO occupancy 0..DEPTH
//   busy_o                                 FIFO not empty or FSM not idle
module pb_bus_master #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic                       cmd_we_i,
    input  logic [ADDR_W-1:0]          cmd_addr_i,
    input  logic [DATA_W-1:0]          cmd_data_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic                       rsp_we_o,
    output logic [ADDR_W-1:0]          rsp_addr_o,
    output logic [DATA_W-1:0]          rsp_data_o,
    output logic [ADDR_W-1:0]          addr_o,
    output logic [DATA_W-1:0]          data_o,
    output logic                       rd_o,
    output logic                       wr_o,
    input  logic [DATA_W-1:0]          data_i,
    output logic [$clog2(DEPTH):0]     fifo_count_o,
    output logic                       busy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [ENT_W-1:0]  fifo_mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop, full, empty;
    logic [ENT_W-1:0]  head;
    logic              head_we;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    assign cmd_ready_o = !full;
    assign push        = cmd_valid_i && !full;
    assign head        = fifo_mem_q[rd_ptr_q];
    assign head_we     = head[ENT_W-1];
    assign head_addr   = head[ENT_W-2 -: ADDR_W];
    assign head_data   = head[DATA_W-1:0];

    // Storage needs no reset: entries are only read when count_q says they are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {cmd_we_i, cmd_addr_i, cmd_data_i};
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // ---------------------------------------------------------------- FSM
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_we_q, rsp_we_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_we_d    = rsp_we_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    addr_d  = head_addr;
                    data_d  = head_data;
                    rd_d    = !head_we;
                    wr_d    = head_we;
                    state_d = ST_ISSUE;
                end
            end
            // The strobe is high for this one cycle; every exit goes through a
            // non-strobing state, which guarantees the idle gap between strobes.
            ST_ISSUE: begin
                if (rd_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = 1'b0;
                    rsp_addr_d  = addr_q;
                    rsp_data_d  = data_i;
                    state_d     = ST_RESP;
                end else begin
`ifdef PB_BUS_MASTER_WRACK_EN
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = 1'b1;
                    rsp_addr_d  = addr_q;
                    rsp_data_d  = data_q;
                    state_d     = ST_RESP;
`else
                    state_d     = ST_IDLE;
`endif
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign addr_o       = addr_q;
    assign data_o       = data_q;
    assign rd_o         = rd_q;
    assign wr_o         = wr_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_we_o     = rsp_we_q;
    assign rsp_addr_o   = rsp_addr_q;
    assign rsp_data_o   = rsp_data_q;
    assign fifo_count_o = count_q;
    assign busy_o       = !empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_pb_bus_master.sv
// tb/tb_pb_bus_master.sv - self-checking bench for pb_bus_master
module tb_pb_bus_master;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } op_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_we = 1'b0;
    logic [7:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic       rsp_we;
    logic [7:0] rsp_addr;
    logic [7:0] rsp_data;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       rd;
    logic       wr;
    logic [7:0] bus_rdata;
    logic [2:0] fifo_count;
    logic       busy;

    op_t exp_bus[$];
    op_t exp_rsp[$];
    op_t mon_e;
    int  n_cmp = 0;
    int  n_err = 0;
    logic prev_strobe = 1'b0;

    always #5 clk = ~clk;

    pb_bus_master #(.DEPTH(4), .ADDR_W(8), .DATA_W(8)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_we_i     (cmd_we),
        .cmd_addr_i   (cmd_addr),
        .cmd_data_i   (cmd_data),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_we_o     (rsp_we),
        .rsp_addr_o   (rsp_addr),
        .rsp_data_o   (rsp_data),
        .addr_o       (bus_addr),
        .data_o       (bus_wdata),
        .rd_o         (rd),
        .wr_o         (wr),
        .data_i       (bus_rdata),
        .fifo_count_o (fifo_count),
        .busy_o       (busy)
    );

    // Responder: address-dependent read data, 0xFF at 0x1B.
    function automatic logic [7:0] resp_val(input logic [7:0] a);
        return (a == 8'h1B) ? 8'hFF : (a ^ 8'hE4);
    endfunction

    assign bus_rdata = rd ? resp_val(bus_addr) : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic we, input logic [7:0] a, input logic [7:0] d);
        op_t o;
        bit  acc = 1'b0;
        o.we = we; o.addr = a; o.data = d;
        exp_bus.push_back(o);
        if (!we) begin
            o.data = resp_val(a);
            exp_rsp.push_back(o);
        end
`ifdef PB_BUS_MASTER_WRACK_EN
        else exp_rsp.push_back(o);
`endif
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_data = d;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (cmd_ready) acc = 1'b1;
        end
        if (acc) begin
            @(posedge clk);
            #1;
        end else begin
            chk("accept_timeout", 32'd0, 32'd1);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_bus.size() == 0 && exp_rsp.size() == 0 && !busy) break;
        end
        chk(tag, {31'd0, (exp_bus.size() == 0 && exp_rsp.size() == 0 && !busy)}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every strobe and every response handshake pops an expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd || wr) begin
                chk("strobe_exclusive", {31'd0, rd && wr}, 32'd0);
                chk("strobe_gap", {31'd0, prev_strobe}, 32'd0);
                if (exp_bus.size() == 0) begin
                    chk("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_bus.pop_front();
                    chk("bus_we", {31'd0, wr}, {31'd0, mon_e.we});
                    chk("bus_addr", {24'd0, bus_addr}, {24'd0, mon_e.addr});
                    if (mon_e.we) chk("bus_data", {24'd0, bus_wdata}, {24'd0, mon_e.data});
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_rsp.pop_front();
                    chk("rsp_we", {31'd0, rsp_we}, {31'd0, mon_e.we});
                    chk("rsp_addr", {24'd0, rsp_addr}, {24'd0, mon_e.addr});
                    chk("rsp_data", {24'd0, rsp_data}, {24'd0, mon_e.data});
                end
            end
            prev_strobe = rd || wr;
        end else begin
            prev_strobe = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int stale;
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rd", {31'd0, rd}, 32'd0);
        chk("rst_wr", {31'd0, wr}, 32'd0);
        chk("rst_count", {29'd0, fifo_count}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_addr", {24'd0, bus_addr}, 32'd0);
        chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single write: strobe in the cycle after edge N+1
        send(1'b1, 8'h08, 8'h5A);
        @(negedge clk);
        chk("t1_wr_early", {31'd0, wr}, 32'd0);
        @(negedge clk);
        chk("t1_wr_high", {31'd0, wr}, 32'd1);
        chk("t1_addr", {24'd0, bus_addr}, 32'h08);
        chk("t1_data", {24'd0, bus_wdata}, 32'h5A);
        @(negedge clk);
        chk("t1_wr_pulse", {31'd0, wr}, 32'd0);
`ifndef PB_BUS_MASTER_WRACK_EN
        chk("t1_no_rsp", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("t1_no_rsp2", {31'd0, rsp_valid}, 32'd0);
`endif
        drain("t1_drain");

        // Single read of 0x1B
        send(1'b0, 8'h1B, 8'h00);
        @(negedge clk);
        chk("t2_rd_early", {31'd0, rd}, 32'd0);
        @(negedge clk);
        chk("t2_rd_high", {31'd0, rd}, 32'd1);
        chk("t2_addr", {24'd0, bus_addr}, 32'h1B);
        @(negedge clk);
        chk("t2_rd_pulse", {31'd0, rd}, 32'd0);
        chk("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t2_rsp_data", {24'd0, rsp_data}, 32'hFF);
        chk("t2_rsp_addr", {24'd0, rsp_addr}, 32'h1B);
        chk("t2_rsp_we", {31'd0, rsp_we}, 32'd0);
        drain("t2_drain");

        // Stalled response fills the FIFO
        rsp_ready = 1'b0;
        send(1'b0, 8'h06, 8'h00);
        for (int i = 0; i < 4; i++) send(1'b1, 8'(i), 8'(8'hA0 + i));
        repeat (3) begin
            @(negedge clk);
            chk("t3_count_full", {29'd0, fifo_count}, 32'd4);
            chk("t3_ready_low", {31'd0, cmd_ready}, 32'd0);
            chk("t3_no_strobe", {30'd0, rd, wr}, 32'd0);
            chk("t3_rsp_hold", {23'd0, rsp_valid, rsp_data}, {23'd0, 1'b1, resp_val(8'h06)});
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t3_cnt_after_hs", {29'd0, fifo_count}, 32'd4);
        chk("t3_rsp_cleared", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("t3_cnt_after_pop", {29'd0, fifo_count}, 32'd3);
        chk("t3_ready_back", {31'd0, cmd_ready}, 32'd1);
        chk("t3_first_wr", {23'd0, wr, bus_addr}, {23'd0, 1'b1, 8'h00});
        drain("t3_drain");

        // Back-to-back writes
        for (int i = 0; i < 8; i++) send(1'b1, 8'(8'h40 + i), 8'($urandom_range(0, 255)));
        drain("t4_drain");

        // Reset while a read strobe is on the bus with 3 entries queued
        rsp_ready = 1'b0;
        send(1'b0, 8'h30, 8'h00);
        send(1'b0, 8'h31, 8'h00);
        send(1'b1, 8'h50, 8'h11);
        send(1'b1, 8'h51, 8'h22);
        send(1'b1, 8'h52, 8'h33);
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t5_rd_before_rst", {23'd0, rd, bus_addr}, {23'd0, 1'b1, 8'h31});
        chk("t5_cnt_before_rst", {29'd0, fifo_count}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rd_rst", {31'd0, rd}, 32'd0);
        chk("t5_rsp_valid_rst", {31'd0, rsp_valid}, 32'd0);
        chk("t5_count_rst", {29'd0, fifo_count}, 32'd0);
        chk("t5_ready_rst", {31'd0, cmd_ready}, 32'd1);
        exp_bus.delete();
        exp_rsp.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (rd || wr || rsp_valid) stale++;
        end
        chk("t5_no_stale", 32'(stale), 32'd0);
        @(posedge clk);
        #1;
        send(1'b0, 8'h1B, 8'h00);
        drain("t5_post_rst_drain");

`ifdef PB_BUS_MASTER_WRACK_EN
        rsp_ready = 1'b0;
        send(1'b1, 8'hFF, 8'h01);
        send(1'b0, 8'h1B, 8'h00);
        repeat (4) begin
            @(negedge clk);
        end
        chk("t6_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t6_rsp_we", {31'd0, rsp_we}, 32'd1);
        chk("t6_rsp_addr", {24'd0, rsp_addr}, 32'hFF);
        chk("t6_rsp_data", {24'd0, rsp_data}, 32'h01);
        chk("t6_read_waits", {29'd0, fifo_count}, 32'd1);
        rsp_ready = 1'b1;
        drain("t6_drain");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
